// File: rtl/fetch_stage_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: default bus widths and
// the 2-bit fetch FSM state encoding.
package fetch_stage_unit_pkg;

  localparam int ADDRESS_LEN     = 32;
  localparam int INSTRUCTION_LEN = 32;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_WAIT = 2'd2,
    FETCH_HOLD = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_unit_if.sv
// Instruction-memory port: single-outstanding request/response.
//   imem_req_valid / imem_req_ready / imem_req_address : request channel
//   imem_resp_valid / imem_resp_data                     : one-cycle response pulse
// master = fetch stage, slave = instruction memory.
interface fetch_stage_unit_if #(
  parameter int ADDRESS_LEN     = fetch_stage_unit_pkg::ADDRESS_LEN,
  parameter int INSTRUCTION_LEN = fetch_stage_unit_pkg::INSTRUCTION_LEN
);
  logic                       imem_req_valid;
  logic                       imem_req_ready;
  logic [ADDRESS_LEN-1:0]     imem_req_address;
  logic                       imem_resp_valid;
  logic [INSTRUCTION_LEN-1:0] imem_resp_data;

  modport master (
    output imem_req_valid,
    output imem_req_address,
    input  imem_req_ready,
    input  imem_resp_valid,
    input  imem_resp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_address,
    output imem_req_ready,
    output imem_resp_valid,
    output imem_resp_data
  );
endinterface

// File: rtl/fetch_stage_unit_if_id_pipeline_reg.sv
// IF/ID pipeline register: (valid, pc, instruction) presented to ID.
//   clk, rst      : clock, async active-low reset
//   load_i        : capture pc_i/instr_i with valid=1
//   freeze_i      : hold all three outputs
//   flush_i       : kill valid (branch redirect); highest priority
//   valid_o/pc_o/instr_o : registered outputs
// With no load, freeze or flush the register emits a bubble (valid=0) and
// keeps its pc/instruction payload.
module if_id_pipeline_reg #(
  parameter int ADDRESS_LEN     = fetch_stage_unit_pkg::ADDRESS_LEN,
  parameter int INSTRUCTION_LEN = fetch_stage_unit_pkg::INSTRUCTION_LEN
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load_i,
  input  logic                       freeze_i,
  input  logic                       flush_i,
  input  logic [ADDRESS_LEN-1:0]     pc_i,
  input  logic [INSTRUCTION_LEN-1:0] instr_i,
  output logic                       valid_o,
  output logic [ADDRESS_LEN-1:0]     pc_o,
  output logic [INSTRUCTION_LEN-1:0] instr_o
);
  logic                       valid_q;
  logic [ADDRESS_LEN-1:0]     pc_q;
  logic [INSTRUCTION_LEN-1:0] instr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      pc_q    <= pc_i;
      instr_q <= instr_i;
    end else if (!freeze_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;
endmodule

// File: rtl/fetch_stage_unit.sv
// Instruction-fetch stage: owns the PC, runs the IDLE/REQ/WAIT/HOLD fetch FSM
// against a single-outstanding memory port, and feeds the IF/ID register.
//   clk, rst                      : clock, async active-low reset
//   freeze                        : hazard stall, holds IF/ID and PC
//   branch_taken, branch_address  : EXE redirect (beats freeze and responses)
//   imem                          : instruction-memory port (master side)
//   id_valid, id_pc, id_instruction : IF/ID register to ID
module fetch_stage_unit #(
  parameter int                            ADDRESS_LEN     = fetch_stage_unit_pkg::ADDRESS_LEN,
  parameter int                            INSTRUCTION_LEN = fetch_stage_unit_pkg::INSTRUCTION_LEN,
  parameter logic [ADDRESS_LEN-1:0]        RESET_PC        = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       freeze,
  input  logic                       branch_taken,
  input  logic [ADDRESS_LEN-1:0]     branch_address,
  fetch_stage_unit_if.master         imem,
  output logic                       id_valid,
  output logic [ADDRESS_LEN-1:0]     id_pc,
  output logic [INSTRUCTION_LEN-1:0] id_instruction
);
  import fetch_stage_unit_pkg::*;

  fetch_state_e               state_q, state_d;
  logic [ADDRESS_LEN-1:0]     pc_q, pc_d;
  logic                       drop_q, drop_d;
  logic [ADDRESS_LEN-1:0]     hold_pc_q, hold_pc_d;
  logic [INSTRUCTION_LEN-1:0] hold_instr_q, hold_instr_d;

  logic                       load;
  logic [ADDRESS_LEN-1:0]     load_pc;
  logic [INSTRUCTION_LEN-1:0] load_instr;
  logic [ADDRESS_LEN-1:0]     pc_plus4;

  assign pc_plus4              = pc_q + ADDRESS_LEN'(4);
  assign imem.imem_req_valid   = (state_q == FETCH_REQ) && !branch_taken;
  assign imem.imem_req_address = pc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= FETCH_IDLE;
      pc_q         <= RESET_PC;
      drop_q       <= 1'b0;
      hold_pc_q    <= '0;
      hold_instr_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drop_q       <= drop_d;
      hold_pc_q    <= hold_pc_d;
      hold_instr_q <= hold_instr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_d       = drop_q;
    hold_pc_d    = hold_pc_q;
    hold_instr_d = hold_instr_q;
    load         = 1'b0;
    load_pc      = pc_plus4;
    load_instr   = imem.imem_resp_data;

    if (branch_taken) begin
      pc_d = branch_address;
      unique case (state_q)
        FETCH_WAIT: begin
          // A response already here is simply dropped; otherwise the
          // in-flight one must be swallowed when it lands.
          if (imem.imem_resp_valid) begin
            drop_d  = 1'b0;
            state_d = FETCH_REQ;
          end else begin
            drop_d  = 1'b1;
          end
        end
        FETCH_HOLD: begin
          hold_pc_d    = '0;
          hold_instr_d = '0;
          state_d      = FETCH_REQ;
        end
        default: ; // IDLE and REQ stay put with the new PC
      endcase
    end else begin
      unique case (state_q)
        FETCH_IDLE: state_d = FETCH_REQ;
        FETCH_REQ: begin
          if (imem.imem_req_ready) state_d = FETCH_WAIT;
        end
        FETCH_WAIT: begin
          if (imem.imem_resp_valid) begin
            if (drop_q) begin
              drop_d  = 1'b0;
              state_d = FETCH_REQ;
            end else if (!freeze) begin
              load    = 1'b1;
              pc_d    = pc_plus4;
              state_d = FETCH_REQ;
            end else begin
              hold_pc_d    = pc_plus4;
              hold_instr_d = imem.imem_resp_data;
              state_d      = FETCH_HOLD;
            end
          end
        end
        FETCH_HOLD: begin
          if (!freeze) begin
            load       = 1'b1;
            load_pc    = hold_pc_q;
            load_instr = hold_instr_q;
            pc_d       = pc_plus4;
            state_d    = FETCH_REQ;
          end
        end
        default: state_d = FETCH_IDLE;
      endcase
    end
  end

  if_id_pipeline_reg #(
    .ADDRESS_LEN     (ADDRESS_LEN),
    .INSTRUCTION_LEN (INSTRUCTION_LEN)
  ) u_if_id (
    .clk      (clk),
    .rst      (rst),
    .load_i   (load),
    .freeze_i (freeze),
    .flush_i  (branch_taken),
    .pc_i     (load_pc),
    .instr_i  (load_instr),
    .valid_o  (id_valid),
    .pc_o     (id_pc),
    .instr_o  (id_instruction)
  );
endmodule

// File: tb/tb_fetch_stage_unit.sv
// Directed bench for fetch_stage_unit. Inputs change and outputs are sampled
// on the falling edge; a small memory responder on the rising edge returns
// data = address after a programmable latency.
module tb_fetch_stage_unit;
  import fetch_stage_unit_pkg::*;

  localparam int AL = 32;
  localparam int IL = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          freeze = 1'b0;
  logic          branch_taken = 1'b0;
  logic [AL-1:0] branch_address = '0;
  logic          id_valid;
  logic [AL-1:0] id_pc;
  logic [IL-1:0] id_instruction;

  int total = 0;
  int bad   = 0;
  int acc_cnt = 0;
  int acc0  = 0;
  int lat   = 1;
  int cnt   = 0;
  logic [AL-1:0] lat_addr = '0;

  fetch_stage_unit_if #(.ADDRESS_LEN(AL), .INSTRUCTION_LEN(IL)) imem();

  fetch_stage_unit #(.ADDRESS_LEN(AL), .INSTRUCTION_LEN(IL), .RESET_PC('0)) dut (
    .clk            (clk),
    .rst            (rst),
    .freeze         (freeze),
    .branch_taken   (branch_taken),
    .branch_address (branch_address),
    .imem           (imem),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
    .id_instruction (id_instruction)
  );

  always #5 clk = ~clk;

  // Memory responder: response becomes visible `lat` edges after acceptance.
  always @(posedge clk) begin
    imem.imem_resp_valid <= 1'b0;
    if (cnt == 1) begin
      imem.imem_resp_valid <= 1'b1;
      imem.imem_resp_data  <= lat_addr;
    end
    if (cnt > 0) cnt <= cnt - 1;
    if (imem.imem_req_valid && imem.imem_req_ready) begin
      acc_cnt <= acc_cnt + 1;
      if (lat <= 1) begin
        imem.imem_resp_valid <= 1'b1;
        imem.imem_resp_data  <= imem.imem_req_address;
      end else begin
        cnt      <= lat - 1;
        lat_addr <= imem.imem_req_address;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_id(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] ins);
    chk({tag, ".id_valid"}, {31'd0, id_valid}, {31'd0, v});
    chk({tag, ".id_pc"}, id_pc, pc);
    chk({tag, ".id_instr"}, id_instruction, ins);
  endtask

  task automatic chk_req(input string tag, input logic v, input logic [31:0] a);
    chk({tag, ".req_valid"}, {31'd0, imem.imem_req_valid}, {31'd0, v});
    chk({tag, ".req_addr"}, imem.imem_req_address, a);
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    imem.imem_req_ready = 1'b1;
    #1;
    chk_id("reset", 1'b0, 32'h0, 32'h0);
    chk_req("reset", 1'b0, 32'h0);
    nxt(); nxt();
    rst = 1'b1;
    #1;
    chk_req("quiet", 1'b0, 32'h0);

    // straight-line fetch
    nxt(); chk_req("sl.r0", 1'b1, 32'h0); chk_id("sl.r0", 1'b0, 32'h0, 32'h0);
    nxt(); chk_req("sl.w0", 1'b0, 32'h0);
    nxt(); chk_id("sl.i0", 1'b1, 32'h4, 32'h0); chk_req("sl.r4", 1'b1, 32'h4);
    nxt(); chk_id("sl.bub", 1'b0, 32'h4, 32'h0); chk_req("sl.w4", 1'b0, 32'h4);
    nxt(); chk_id("sl.i4", 1'b1, 32'h8, 32'h4); chk_req("sl.r8", 1'b1, 32'h8);
    nxt();
    nxt(); chk_id("sl.i8", 1'b1, 32'hC, 32'h8); chk_req("sl.rC", 1'b1, 32'hC);

    // back-pressure at 0x10
    nxt();
    nxt(); chk_id("bp.iC", 1'b1, 32'h10, 32'hC); chk_req("bp.r10", 1'b1, 32'h10);
    acc0 = acc_cnt;
    imem.imem_req_ready = 1'b0;
    nxt(); chk_req("bp.s1", 1'b1, 32'h10);
    nxt(); chk_req("bp.s2", 1'b1, 32'h10);
    nxt(); chk_req("bp.s3", 1'b1, 32'h10);
    imem.imem_req_ready = 1'b1;
    nxt(); chk_req("bp.w10", 1'b0, 32'h10);
    nxt(); chk_id("bp.i10", 1'b1, 32'h14, 32'h10); chk_req("bp.r14", 1'b1, 32'h14);
    chk("bp.accepts", acc_cnt - acc0, 32'd1);

    // freeze on the 0x20 response
    repeat (6) nxt();
    chk_id("fz.i1C", 1'b1, 32'h20, 32'h1C); chk_req("fz.r20", 1'b1, 32'h20);
    nxt(); chk_req("fz.w20", 1'b0, 32'h20); chk_id("fz.pre", 1'b0, 32'h20, 32'h1C);
    freeze = 1'b1;
    nxt(); chk_id("fz.h1", 1'b0, 32'h20, 32'h1C); chk_req("fz.h1", 1'b0, 32'h20);
    nxt(); chk_id("fz.h2", 1'b0, 32'h20, 32'h1C); chk_req("fz.h2", 1'b0, 32'h20);
    nxt(); chk_id("fz.h3", 1'b0, 32'h20, 32'h1C); chk_req("fz.h3", 1'b0, 32'h20);
    freeze = 1'b0;
    nxt(); chk_id("fz.rel", 1'b1, 32'h24, 32'h20); chk_req("fz.r24", 1'b1, 32'h24);

    // branch in REQ to 0x40, then branch in WAIT to 0x100
    branch_taken = 1'b1; branch_address = 32'h40;
    #1; chk_req("br.req_sup", 1'b0, 32'h24);
    nxt(); branch_taken = 1'b0;
    #1; chk_id("br.flush", 1'b0, 32'h24, 32'h20); chk_req("br.r40", 1'b1, 32'h40);
    lat = 2;
    nxt(); chk_req("bw.w40", 1'b0, 32'h40);
    branch_taken = 1'b1; branch_address = 32'h100;
    nxt(); branch_taken = 1'b0;
    chk_id("bw.flush", 1'b0, 32'h24, 32'h20); chk_req("bw.wait", 1'b0, 32'h100);
    nxt(); chk_id("bw.drop", 1'b0, 32'h24, 32'h20); chk_req("bw.r100", 1'b1, 32'h100);
    lat = 1;

    // branch + freeze together in HOLD
    nxt(); chk_req("bh.w100", 1'b0, 32'h100);
    freeze = 1'b1;
    nxt(); chk_req("bh.hold", 1'b0, 32'h100); chk_id("bh.hold", 1'b0, 32'h24, 32'h20);
    branch_taken = 1'b1; branch_address = 32'h200;
    nxt(); branch_taken = 1'b0; freeze = 1'b0;
    #1; chk_id("bh.flush", 1'b0, 32'h24, 32'h20); chk_req("bh.r200", 1'b1, 32'h200);
    nxt();
    nxt(); chk_id("bh.i200", 1'b1, 32'h204, 32'h200); chk_req("bh.r204", 1'b1, 32'h204);

    // PC wrap
    branch_taken = 1'b1; branch_address = 32'hFFFF_FFFC;
    nxt(); branch_taken = 1'b0;
    #1; chk_req("wr.rFFC", 1'b1, 32'hFFFF_FFFC); chk_id("wr.flush", 1'b0, 32'h204, 32'h200);
    nxt();
    nxt(); chk_id("wr.iFFC", 1'b1, 32'h0, 32'hFFFF_FFFC); chk_req("wr.r0", 1'b1, 32'h0);
    lat = 3;

    // reset mid-WAIT, late response lands in REQ
    nxt(); chk_req("rs.w0", 1'b0, 32'h0);
    rst = 1'b0;
    #1; chk_id("rs.async", 1'b0, 32'h0, 32'h0); chk_req("rs.async", 1'b0, 32'h0);
    nxt(); rst = 1'b1;
    #1; chk_req("rs.idle", 1'b0, 32'h0);
    nxt(); chk_req("rs.r0", 1'b1, 32'h0); chk_id("rs.r0", 1'b0, 32'h0, 32'h0);
    lat = 1;
    nxt(); chk_id("rs.late", 1'b0, 32'h0, 32'h0); chk_req("rs.w0b", 1'b0, 32'h0);
    nxt(); chk_id("rs.i0", 1'b1, 32'h4, 32'h0); chk_req("rs.r4", 1'b1, 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_stage_unit.md
Name: fetch_stage_unit

Overview:
- Instruction-fetch stage and IF/ID pipeline register of the ARM pipeline, directly upstream of the ID stage.
- It consumes the freeze from the hazard detection unit and the branch redirect from EXE.
- It owns the PC and drives a single-outstanding request/response instruction-memory port.
- Fetched instructions are presented to ID as a registered (valid, pc, instruction) triple.

Parameters:
ADDRESS_LEN, 32, width of PC and memory address
INSTRUCTION_LEN, 32, instruction width
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset asserted)
freeze  in  1  hazard_detected from the hazard detection unit; hold IF/ID and PC
branch_taken  in  1  EXE-stage redirect
branch_address  in  ADDRESS_LEN  redirect target
imem_req_valid  out  1  request valid
imem_req_ready  in  1  memory accepts request when valid&ready
imem_req_address  out  ADDRESS_LEN  equals PC register
imem_resp_valid  in  1  one-cycle pulse with instruction data
imem_resp_data  in  INSTRUCTION_LEN  fetched instruction
id_valid  out  1  IF/ID contents valid
id_pc  out  ADDRESS_LEN  fetch address + 4
id_instruction  out  INSTRUCTION_LEN  fetched instruction

Behaviour:
- Reset (rst=0, asynchronous):
  - pc=RESET_PC, state=IDLE, drop=0, hold buffer cleared.
  - id_valid=0, id_pc=0, id_instruction=0.
  - imem_req_valid=0.
- States: IDLE, REQ, WAIT, HOLD.
- IDLE: always go to REQ next cycle. This gives one quiet cycle after reset release.
- imem_req_valid = (state==REQ) && !branch_taken. This output is combinational.
- REQ:
  - On valid&ready, go to WAIT.
  - While ready=0, stay in REQ with the address held stable.
- WAIT:
  - Response handling applies only when imem_resp_valid=1. Memory never responds in the acceptance cycle (minimum latency 1).
  - Response with drop=1: discard the data, clear drop, go to REQ.
  - Response with freeze=0: load IF/ID with valid=1, id_pc=pc+4, data. Then pc<=pc+4, go to REQ.
  - Response with freeze=1: capture data and pc+4 into the hold buffer, go to HOLD.
- HOLD:
  - When freeze=0: load IF/ID from the hold buffer, pc<=pc+4, go to REQ.
  - When freeze=1: stay in HOLD.
- IF/ID register:
  - It changes only on a load event or a branch.
  - freeze=1 holds all three id_* outputs unchanged.
  - If a cycle has no load event, no freeze and no branch, id_valid<=0 and id_pc/id_instruction are held. ID therefore sees a bubble.
- Branch (branch_taken=1) has priority over freeze and over any response:
  - Effects in every state: id_valid<=0 and pc<=branch_address.
  - IDLE: stay IDLE.
  - REQ: stay in REQ. No request is issued that cycle.
  - WAIT, no response this cycle: set drop=1 and stay in WAIT. The in-flight response is discarded on arrival.
  - WAIT, response this cycle: discard it and go to REQ.
  - HOLD: discard the hold buffer and go to REQ.
- Responses arriving in IDLE, REQ or HOLD are ignored.
- PC arithmetic is modulo 2^ADDRESS_LEN. 0xFFFFFFFC+4 wraps to 0. The PC is not alignment-checked.
- Reset asserted mid-WAIT: all state returns to reset values. A late response after reset release arrives in IDLE/REQ and is ignored.
- Throughput is at most one instruction per 2 cycles at 1-cycle memory latency.

Decomposition:
- Shared package/Defines: `ADDRESS_LEN`, `INSTRUCTION_LEN` and the state encodings FETCH_IDLE, FETCH_REQ, FETCH_WAIT, FETCH_HOLD (2-bit).
- One natural sub-module: if_id_pipeline_reg. It holds valid/pc/instruction and takes load, freeze and flush inputs, with async active-low reset.
- The FSM, PC and hold buffer stay in fetch_stage_unit.

Test Plan:
1. Straight-line fetch:
   - Stimulus: reset release, ready=1, 1-cycle latency, data = address.
   - Required: requests at 0x0, 0x4, 0x8. id_valid pulses with id_pc 0x4, 0x8, 0xC and the matching instructions, each appearing one cycle after its response.
2. Back-pressure:
   - Stimulus: imem_req_ready=0 for 3 cycles in REQ at pc=0x10.
   - Required: imem_req_valid stays 1 with address 0x10 stable. Exactly one accept occurs when ready rises.
3. Freeze on response:
   - Stimulus: freeze=1 in the response cycle for pc=0x20, held 2 further cycles.
   - Required: state HOLD, IF/ID unchanged during freeze. On freeze release, id_pc=0x24, id_valid=1, next request at 0x24.
4. Branch in WAIT:
   - Stimulus: branch_taken with branch_address=0x100 one cycle before the 0x40 response arrives.
   - Required: id_valid=0, the 0x40 data is never presented, next request address is 0x100.
5. Branch and freeze together in HOLD:
   - Required: id_valid=0, hold buffer discarded, request at branch_address on the following cycle.
6. Reset mid-WAIT:
   - Stimulus: rst=0 asynchronously between edges, then a late response arrives.
   - Required: outputs clear immediately, the late response is ignored, the first post-reset request is at RESET_PC.
